// File: rtl/song_sequencer.sv
// Song note-table sequencer: walks note_index through a duration table,
// holding each note for note_dur cycles, then an articulation gap, then advancing.
module song_sequencer #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int NUM_NOTES  = 19,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int IDX_W      = 11,
  parameter int DUR_W      = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop_en,
  input  logic [DUR_W-1:0] note_dur,
  output logic [IDX_W-1:0] note_index,
  output logic             note_active,
  output logic             note_start,
  output logic             song_done,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);
  localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  if (CLOCK_FREQ <= 0 || NUM_NOTES < 1 || NUM_NOTES > (1 << IDX_W) || GAP_CYCLES < 0)
  begin : g_param_check
    $error("song_sequencer: invalid parameter set");
  end

  state_t           state_reg, state_next;
  logic [DUR_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             mute_reg, mute_next;
  logic             advance;
  logic             active_reg, nstart_reg, done_reg, busy_reg;

  // mute_reg marks a frozen cycle: pause seen at the previous edge while
  // playing, so the current cycle is silent and does not count down.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    advance    = 1'b0;
    if (stop) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = LOAD;
            idx_next   = '0;
          end
        end
        LOAD: begin
          if (note_dur == '0) begin
            state_next = DONE;
          end else begin
            cnt_next   = note_dur - DUR_W'(1);
            state_next = PLAY;
          end
        end
        PLAY: begin
          if (!mute_reg) begin
            if (cnt_reg != '0) begin
              cnt_next = cnt_reg - DUR_W'(1);
            end else if (HAS_GAP) begin
              cnt_next   = GAP_LOAD;
              state_next = GAP;
            end else begin
              advance = 1'b1;
            end
          end
        end
        GAP: begin
          if (!mute_reg) begin
            if (cnt_reg != '0) cnt_next = cnt_reg - DUR_W'(1);
            else               advance  = 1'b1;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase

      if (advance) begin
        if (idx_reg < LAST_IDX) begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = LOAD;
        end else if (loop_en) begin
          idx_next   = '0;
          state_next = LOAD;
        end else begin
          state_next = DONE;
        end
      end
    end
  end

  always_comb begin
    mute_next = !stop && pause &&
                (state_reg == PLAY || state_reg == GAP) &&
                (state_next == PLAY || state_next == GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      mute_reg   <= 1'b0;
      active_reg <= 1'b0;
      nstart_reg <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      mute_reg   <= mute_next;
      active_reg <= (state_next == PLAY) && !mute_next;
      nstart_reg <= (state_reg == LOAD) && (state_next == PLAY);
      done_reg   <= (state_next == DONE);
      busy_reg   <= (state_next != IDLE);
    end
  end

  assign note_index  = idx_reg;
  assign note_active = active_reg;
  assign note_start  = nstart_reg;
  assign song_done   = done_reg;
  assign busy        = busy_reg;

endmodule
